hci_periph_job_target: RTL and testbench
========================================

Name: hci_periph_job_target

Overview:
- Responder (target) side of the HWPE peripheral control bus: req/gnt/add/wen/be/data/id, r_data/r_valid/r_id.
- Holds a staging register file for one datamover job (pointers, lengths, strides, transpose mode).
- A TRIGGER write commits the staged job into a small job queue. The queue presents jobs to the datamover through a valid/ready handshake.
- Counts completions and raises an event pulse per completion. Sits between the system control master and each datamover instance.

Parameters:
- ID_WIDTH, 8, width of id/r_id (system ID_PERIPH)
- N_CTX, 2, job queue depth (>=1)
- JOB_ID_WIDTH, 4, width of wrapping job-id counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  bus request
- gnt_o  out  1  bus grant
- add_i  in  32  byte address; bits [6:2] select register
- wen_i  in  1  0=write, 1=read
- be_i  in  4  byte enables
- data_i  in  32  write data
- id_i  in  ID_WIDTH  transaction id
- r_data_o  out  32  read data
- r_valid_o  out  1  response valid
- r_id_o  out  ID_WIDTH  response id
- job_valid_o  out  1  queue head valid
- job_ready_i  in  1  datamover accepts head
- job_cfg_o  out  hci_job_cfg_t  head job config (13 x 32 bit)
- job_id_o  out  JOB_ID_WIDTH  head job id
- done_i  in  1  one-cycle pulse: datamover finished a job
- evt_o  out  1  completion event pulse
- clear_o  out  1  soft-clear pulse to datamover

Behaviour:
- Reset (rst_i high at posedge): all outputs 0. Staging regs, queue, counters and sticky flags cleared.
- Grant: gnt_o = req_i combinationally. Every request is accepted in the cycle it is presented.
- Handshake at the posedge with req_i & gnt_o. Response exactly 1 cycle later: r_valid_o=1 for one cycle and r_id_o = captured id_i.
  - Read: r_data_o = register value sampled at handshake.
  - Write: r_data_o = 0.
  - Back-to-back requests produce back-to-back responses.
- Register map (word index):
  - 0 TRIGGER (W): commit staging to queue.
  - 1 FINISHED (R): 32-bit completion count, wraps.
  - 2 STATUS (R): [0] busy, [1] queue full, [2] overflow sticky, [3] decode-error sticky, [7:4] queue count, [15:8] next job id.
  - 3 SOFT_CLEAR (W).
  - 4..15 reserved.
  - 16..28 staging (RW): IN_PTR, OUT_PTR, LEN0, LEN1, IN_D0/D1/D2_STRIDE, OUT_D0/D1/D2_STRIDE, TRANSP_MODE.
- Staging writes are byte-masked by be_i. be_i is ignored for command registers.
- Reserved or out-of-range index (add_i[31:7] != 0 or index 4..15, 29..31):
  - Read returns 0; write has no effect.
  - Either sets decode-error sticky. Response timing is unchanged.
- TRIGGER, accepted when queue count < N_CTX, evaluated before any same-cycle pop (no bypass):
  - Push staging plus current job id; job id increments, wrapping at 2^JOB_ID_WIDTH.
  - Staging content is retained.
  - When full: push dropped, overflow sticky set, job id unchanged.
- Queue: FIFO. job_valid_o = count != 0. Pop on job_valid_o & job_ready_i. A simultaneous push and pop leaves count unchanged.
- busy = queue non-empty OR a popped job is outstanding. Outstanding counter increments on pop and decrements on done_i. A done_i with zero outstanding is ignored for busy but still counted.
- done_i: FINISHED increments and evt_o pulses the following cycle. Simultaneous done_i and bus read of FINISHED returns the pre-increment value.
- SOFT_CLEAR write: on the next cycle, clear_o pulses once and the queue is flushed.
  - Staging, FINISHED, stickies, outstanding and job id are zeroed.
  - The write's own response is still returned normally.
  - A request in the clear cycle is served with post-clear state.
- Reset mid-transaction: the pending response is dropped; r_valid_o=0 in the cycle after reset.

Decomposition:
- Package hci_periph_job_pkg holds:
  - register index localparams;
  - hci_job_cfg_t packed struct (13 fields, order as map);
  - STATUS bit positions;
  - N_CFG_REGS=13.
- Sub-module hci_periph_job_fifo: parameterised depth/type FIFO with push, pop, count, full, empty, flush, synchronous active-high reset.

Test Plan:
- Reset then read STATUS at offset 0x08 -> r_data=0x0, r_valid one cycle after grant, r_id echoed (id=0x5A -> r_id=0x5A).
- Write staging IN_PTR=0x0, OUT_PTR=0x4, LEN0=0x0000F00F, LEN1=0x0000000F, IN_D0_STRIDE=0x40, then TRIGGER with job_ready_i=0 -> job_valid_o=1, job_cfg_o fields match, job_id_o=0, STATUS[7:4]=1.
- Byte mask: write 0xAABBCCDD to IN_PTR with be=0b0101 over 0x0 -> readback 0x00BB00DD.
- Queue full: N_CTX=2, three TRIGGERs with job_ready_i=0 -> count=2, overflow=1, next job id=2. Then ready=1 -> jobs 0,1 popped in order, busy stays 1 until two done_i pulses.
- done_i pulses x3 -> evt_o three single-cycle pulses one cycle after each; FINISHED reads 3. Read at the same edge as the 3rd done_i returns 2.
- SOFT_CLEAR with queued job and stickies set -> clear_o pulse next cycle, job_valid_o=0, STATUS=0, FINISHED=0, IN_PTR reads 0. Address 0x3C read -> 0, decode-error=1.

Source files
------------

// File: rtl/hci_periph_job_pkg.sv
// Shared definitions for the HWPE peripheral job target: register map,
// STATUS layout and the job configuration record handed to the datamover.
package hci_periph_job_pkg;

    localparam int N_CFG_REGS = 13;

    // Command / status word indices
    localparam logic [4:0] REG_TRIGGER    = 5'd0;
    localparam logic [4:0] REG_FINISHED   = 5'd1;
    localparam logic [4:0] REG_STATUS     = 5'd2;
    localparam logic [4:0] REG_SOFT_CLEAR = 5'd3;

    // Staging word indices (same order as the fields of hci_job_cfg_t)
    localparam logic [4:0] REG_IN_PTR        = 5'd16;
    localparam logic [4:0] REG_OUT_PTR       = 5'd17;
    localparam logic [4:0] REG_LEN0          = 5'd18;
    localparam logic [4:0] REG_LEN1          = 5'd19;
    localparam logic [4:0] REG_IN_D0_STRIDE  = 5'd20;
    localparam logic [4:0] REG_IN_D1_STRIDE  = 5'd21;
    localparam logic [4:0] REG_IN_D2_STRIDE  = 5'd22;
    localparam logic [4:0] REG_OUT_D0_STRIDE = 5'd23;
    localparam logic [4:0] REG_OUT_D1_STRIDE = 5'd24;
    localparam logic [4:0] REG_OUT_D2_STRIDE = 5'd25;
    localparam logic [4:0] REG_TRANSP_MODE   = 5'd26;
    localparam logic [4:0] REG_EXT0          = 5'd27;
    localparam logic [4:0] REG_EXT1          = 5'd28;
    localparam logic [4:0] REG_CFG_FIRST     = REG_IN_PTR;
    localparam logic [4:0] REG_CFG_LAST      = REG_EXT1;

    // STATUS bit positions
    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_DECERR    = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_JOBID_LSB = 8;

    // One complete datamover job; two trailing words carry extension fields
    typedef struct packed {
        logic [31:0] in_ptr;
        logic [31:0] out_ptr;
        logic [31:0] len0;
        logic [31:0] len1;
        logic [31:0] in_d0_stride;
        logic [31:0] in_d1_stride;
        logic [31:0] in_d2_stride;
        logic [31:0] out_d0_stride;
        logic [31:0] out_d1_stride;
        logic [31:0] out_d2_stride;
        logic [31:0] transp_mode;
        logic [31:0] ext0;
        logic [31:0] ext1;
    } hci_job_cfg_t;

    // Byte-masked merge of a bus write into an existing word
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/hci_periph_job_fifo.sv
// Small FIFO of arbitrary element type. A push is accepted only when not
// full at the start of the cycle, so a push into a full queue is dropped even
// if a pop happens in the same cycle. Flush empties the queue in one cycle.
module hci_periph_job_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    output T                           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o    = (r_count == CNT_W'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign data_o    = r_mem[r_rd_ptr];
    assign w_push_ok = push_i & ~full_o;
    assign w_pop_ok  = pop_i & ~empty_o;

    // Storage write; no reset needed since occupancy decides what is visible
    // NOTE: memory contents are not reset; only pointers/count are, which keeps
    // the array as plain storage and stale entries are never observable.
    always_ff @(posedge clk_i) begin
        if (w_push_ok && !flush_i)
            r_mem[r_wr_ptr] <= data_i;
    end

    // Pointer and occupancy bookkeeping
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        end
    end

endmodule

// File: rtl/hci_periph_job_target.sv
// Peripheral-bus target for one datamover: staging registers, TRIGGER into a
// job queue, completion counting/events and soft clear.
module hci_periph_job_target
    import hci_periph_job_pkg::*;
#(
    parameter int ID_WIDTH     = 8,
    parameter int N_CTX        = 2,
    parameter int JOB_ID_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [31:0]             add_i,
    input  logic                    wen_i,
    input  logic [3:0]              be_i,
    input  logic [31:0]             data_i,
    input  logic [ID_WIDTH-1:0]     id_i,
    output logic [31:0]             r_data_o,
    output logic                    r_valid_o,
    output logic [ID_WIDTH-1:0]     r_id_o,
    output logic                    job_valid_o,
    input  logic                    job_ready_i,
    output hci_job_cfg_t            job_cfg_o,
    output logic [JOB_ID_WIDTH-1:0] job_id_o,
    input  logic                    done_i,
    output logic                    evt_o,
    output logic                    clear_o
);

    localparam int CNT_W = $clog2(N_CTX + 1);

    typedef struct packed {
        logic [JOB_ID_WIDTH-1:0] id;
        hci_job_cfg_t            cfg;
    } job_entry_t;

    logic [31:0]             r_stage [N_CFG_REGS];
    logic [JOB_ID_WIDTH-1:0] r_job_id;
    logic [31:0]             r_finished;
    logic [7:0]              r_outstanding;
    logic                    r_overflow;
    logic                    r_decerr;
    logic                    r_evt;
    logic                    r_clear;
    logic                    r_rvalid;
    logic [31:0]             r_rdata;
    logic [ID_WIDTH-1:0]     r_rid;

    logic [4:0]       w_idx;
    logic [3:0]       w_slot;
    logic             w_hi_ok, w_is_cfg, w_is_cmd;
    logic             w_wr, w_trigger, w_soft_clear, w_decerr;
    logic             w_pop, w_full, w_empty, w_busy, w_out_dec;
    logic [CNT_W-1:0] w_count;
    job_entry_t       w_push_entry, w_head;
    logic [31:0]      w_status, w_rd_val;
    logic             w_unused_addr;

    // Address decode; every request is granted immediately
    assign gnt_o         = req_i;
    assign w_idx         = add_i[6:2];
    assign w_slot        = 4'(w_idx - REG_CFG_FIRST);
    assign w_hi_ok       = (add_i[31:7] == '0);
    assign w_is_cfg      = w_hi_ok && (w_idx >= REG_CFG_FIRST) && (w_idx <= REG_CFG_LAST);
    assign w_is_cmd      = w_hi_ok && (w_idx <= REG_SOFT_CLEAR);
    assign w_wr          = req_i & ~wen_i;
    assign w_trigger     = w_wr & w_is_cmd & (w_idx == REG_TRIGGER);
    assign w_soft_clear  = w_wr & w_is_cmd & (w_idx == REG_SOFT_CLEAR);
    assign w_decerr      = req_i & ~(w_is_cfg | w_is_cmd);
    assign w_unused_addr = ^add_i[1:0];

    // Staging array viewed as a job record, in register-map order
    assign w_push_entry.id                = r_job_id;
    assign w_push_entry.cfg.in_ptr        = r_stage[0];
    assign w_push_entry.cfg.out_ptr       = r_stage[1];
    assign w_push_entry.cfg.len0          = r_stage[2];
    assign w_push_entry.cfg.len1          = r_stage[3];
    assign w_push_entry.cfg.in_d0_stride  = r_stage[4];
    assign w_push_entry.cfg.in_d1_stride  = r_stage[5];
    assign w_push_entry.cfg.in_d2_stride  = r_stage[6];
    assign w_push_entry.cfg.out_d0_stride = r_stage[7];
    assign w_push_entry.cfg.out_d1_stride = r_stage[8];
    assign w_push_entry.cfg.out_d2_stride = r_stage[9];
    assign w_push_entry.cfg.transp_mode   = r_stage[10];
    assign w_push_entry.cfg.ext0          = r_stage[11];
    assign w_push_entry.cfg.ext1          = r_stage[12];

    hci_periph_job_fifo #(
        .DEPTH (N_CTX),
        .T     (job_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (w_soft_clear),
        .push_i  (w_trigger),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Head is masked so nothing stale leaks out while the queue is empty
    assign job_valid_o = ~w_empty;
    assign job_cfg_o   = w_empty ? '0 : w_head.cfg;
    assign job_id_o    = w_empty ? '0 : w_head.id;
    assign w_pop       = job_valid_o & job_ready_i;
    assign w_busy      = ~w_empty | (r_outstanding != '0);
    assign w_out_dec   = done_i & (r_outstanding != '0);

    // STATUS word and read-data mux
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_status = '0;
        w_status[STAT_BUSY]                = w_busy;
        w_status[STAT_FULL]                = w_full;
        w_status[STAT_OVERFLOW]            = r_overflow;
        w_status[STAT_DECERR]              = r_decerr;
        w_status[STAT_COUNT_LSB +: 4]      = 4'(w_count);
        w_status[STAT_JOBID_LSB +: 8]      = 8'(r_job_id);
        w_rd_val = '0;
        if (w_is_cfg)
            w_rd_val = r_stage[w_slot];
        else if (w_is_cmd && w_idx == REG_FINISHED)
            w_rd_val = r_finished;
        else if (w_is_cmd && w_idx == REG_STATUS)
            w_rd_val = w_status;
    end

    // Bus response, one cycle after the handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
        end else begin
            r_rvalid <= req_i;
            r_rid    <= req_i ? id_i : '0;
            r_rdata  <= (req_i && wen_i) ? w_rd_val : '0;
        end
    end

    // Staging registers, byte-masked writes
    always_ff @(posedge clk_i) begin
        if (rst_i || w_soft_clear) begin
            for (int i = 0; i < N_CFG_REGS; i++) r_stage[i] <= '0;
        end else if (w_wr && w_is_cfg) begin
            r_stage[w_slot] <= be_merge(r_stage[w_slot], data_i, be_i);
        end
    end

    // Job id, completion count, outstanding jobs and sticky flags
    always_ff @(posedge clk_i) begin
        if (rst_i || w_soft_clear) begin
            r_job_id      <= '0;
            r_finished    <= '0;
            r_outstanding <= '0;
            r_overflow    <= 1'b0;
            r_decerr      <= 1'b0;
        end else begin
            if (w_trigger && !w_full) r_job_id <= r_job_id + 1'b1;
            if (w_trigger && w_full)  r_overflow <= 1'b1;
            if (w_decerr)             r_decerr <= 1'b1;
            if (done_i)               r_finished <= r_finished + 32'd1;
            r_outstanding <= r_outstanding + 8'(w_pop) - 8'(w_out_dec);
        end
    end

    // Completion event and soft-clear pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_evt   <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            r_evt   <= done_i;
            r_clear <= w_soft_clear;
        end
    end

    assign r_valid_o = r_rvalid;
    assign r_data_o  = r_rdata;
    assign r_id_o    = r_rid;
    assign evt_o     = r_evt;
    assign clear_o   = r_clear;

endmodule

// File: tb/tb_hci_periph_job_target.sv
// Directed bench for hci_periph_job_target: register access, queueing,
// overflow, completions, soft clear and reset during a request.
module tb_hci_periph_job_target;
    import hci_periph_job_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_i;
    logic         gnt_o;
    logic [31:0]  add_i;
    logic         wen_i;
    logic [3:0]   be_i;
    logic [31:0]  data_i;
    logic [7:0]   id_i;
    logic [31:0]  r_data_o;
    logic         r_valid_o;
    logic [7:0]   r_id_o;
    logic         job_valid_o;
    logic         job_ready_i;
    hci_job_cfg_t job_cfg_o;
    logic [3:0]   job_id_o;
    logic         done_i;
    logic         evt_o;
    logic         clear_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0]  tid = 8'h10;
    logic [31:0] rdata;

    hci_periph_job_target #(
        .ID_WIDTH     (8),
        .N_CTX        (2),
        .JOB_ID_WIDTH (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .add_i       (add_i),
        .wen_i       (wen_i),
        .be_i        (be_i),
        .data_i      (data_i),
        .id_i        (id_i),
        .r_data_o    (r_data_o),
        .r_valid_o   (r_valid_o),
        .r_id_o      (r_id_o),
        .job_valid_o (job_valid_o),
        .job_ready_i (job_ready_i),
        .job_cfg_o   (job_cfg_o),
        .job_id_o    (job_id_o),
        .done_i      (done_i),
        .evt_o       (evt_o),
        .clear_o     (clear_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus transaction; returns with the response cycle in progress
    task automatic bus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd);
        logic [7:0] my_id;
        my_id = tid;
        tid   = tid + 8'd1;
        @(negedge clk_i);
        req_i = 1'b1; wen_i = wen; add_i = addr; data_i = wdata; be_i = be; id_i = my_id;
        #1 check("gnt", {31'd0, gnt_o}, 32'd1);
        @(posedge clk_i);
        #1 req_i = 1'b0;
        check("r_valid", {31'd0, r_valid_o}, 32'd1);
        check("r_id", {24'd0, r_id_o}, {24'd0, my_id});
        rd = r_data_o;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] d;
        bus(1'b0, addr, wdata, be, d);
        check("wr_rdata", d, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b1, addr, 32'd0, 4'hF, d);
        check(tag, d, exp);
    endtask

    task automatic pulse_done();
        @(negedge clk_i);
        done_i = 1'b1;
        @(posedge clk_i);
        #1 done_i = 1'b0;
        check("evt_high", {31'd0, evt_o}, 32'd1);
        @(posedge clk_i);
        #1 check("evt_low", {31'd0, evt_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; add_i = '0; wen_i = 1'b0; be_i = '0;
        data_i = '0; id_i = '0; job_ready_i = 1'b0; done_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_r_valid", {31'd0, r_valid_o}, 32'd0);
        check("rst_job_valid", {31'd0, job_valid_o}, 32'd0);
        check("rst_evt", {31'd0, evt_o}, 32'd0);
        check("rst_clear", {31'd0, clear_o}, 32'd0);
        check("rst_cfg_zero", {31'd0, (job_cfg_o == '0)}, 32'd1);
        rst_i = 1'b0;

        // Reset-state STATUS read with a specific id
        tid = 8'h5A;
        rd("status_reset", 32'h08, 32'h0);
        @(posedge clk_i);
        #1 check("r_valid_one_cycle", {31'd0, r_valid_o}, 32'd0);

        // Stage one job and trigger it
        wr(32'h40, 32'h0000_0000, 4'hF);
        wr(32'h44, 32'h0000_0004, 4'hF);
        wr(32'h48, 32'h0000_F00F, 4'hF);
        wr(32'h4C, 32'h0000_000F, 4'hF);
        wr(32'h50, 32'h0000_0040, 4'hF);
        wr(32'h00, 32'h0, 4'hF);
        check("job_valid_1", {31'd0, job_valid_o}, 32'd1);
        check("job_id_0", {28'd0, job_id_o}, 32'd0);
        check("cfg_in_ptr", job_cfg_o.in_ptr, 32'h0);
        check("cfg_out_ptr", job_cfg_o.out_ptr, 32'h4);
        check("cfg_len0", job_cfg_o.len0, 32'h0000_F00F);
        check("cfg_len1", job_cfg_o.len1, 32'h0000_000F);
        check("cfg_in_d0", job_cfg_o.in_d0_stride, 32'h40);
        check("cfg_transp", job_cfg_o.transp_mode, 32'h0);
        rd("status_one_job", 32'h08, 32'h0000_0111);

        // Byte-masked staging write; queued job must not change
        wr(32'h40, 32'hAABB_CCDD, 4'b0101);
        rd("in_ptr_bytemask", 32'h40, 32'h00BB_00DD);
        check("queued_cfg_stable", job_cfg_o.in_ptr, 32'h0);

        // Second trigger with be=0 (ignored for commands), third overflows
        wr(32'h00, 32'h0, 4'h0);
        wr(32'h00, 32'h0, 4'hF);
        rd("status_full_ovf", 32'h08, 32'h0000_0227);
        check("head_still_0", {28'd0, job_id_o}, 32'd0);

        // Drain in order
        @(negedge clk_i);
        job_ready_i = 1'b1;
        @(posedge clk_i);
        #1 check("pop0_valid", {31'd0, job_valid_o}, 32'd1);
        check("head_job1", {28'd0, job_id_o}, 32'd1);
        check("job1_in_ptr", job_cfg_o.in_ptr, 32'h00BB_00DD);
        @(posedge clk_i);
        #1 check("drained", {31'd0, job_valid_o}, 32'd0);
        @(negedge clk_i);
        job_ready_i = 1'b0;
        rd("status_outst2", 32'h08, 32'h0000_0205);

        // Completions
        pulse_done();
        rd("status_outst1", 32'h08, 32'h0000_0205);
        pulse_done();
        rd("status_idle", 32'h08, 32'h0000_0204);
        @(negedge clk_i);
        done_i = 1'b1; req_i = 1'b1; wen_i = 1'b1; add_i = 32'h04; id_i = 8'h77;
        @(posedge clk_i);
        #1 done_i = 1'b0; req_i = 1'b0;
        check("finished_same_edge", r_data_o, 32'd2);
        check("evt_same_edge", {31'd0, evt_o}, 32'd1);
        check("rid_same_edge", {24'd0, r_id_o}, 32'h77);
        rd("finished_3", 32'h04, 32'd3);
        rd("status_extra_done", 32'h08, 32'h0000_0204);

        // Queue a job, set decode sticky, then soft clear
        wr(32'h00, 32'h0, 4'hF);
        check("job_id_2", {28'd0, job_id_o}, 32'd2);
        rd("reserved_rd", 32'h34, 32'h0);
        rd("status_pre_clear", 32'h08, 32'h0000_031D);
        wr(32'h0C, 32'h0, 4'hF);
        check("clear_pulse", {31'd0, clear_o}, 32'd1);
        check("clear_flush", {31'd0, job_valid_o}, 32'd0);
        rd("status_in_clear_cycle", 32'h08, 32'h0);
        check("clear_single", {31'd0, clear_o}, 32'd0);
        rd("finished_cleared", 32'h04, 32'h0);
        rd("in_ptr_cleared", 32'h40, 32'h0);
        rd("rd_0x3c", 32'h3C, 32'h0);
        rd("status_decerr", 32'h08, 32'h0000_0008);

        // Out-of-range aliases of TRIGGER and IN_PTR have no effect
        wr(32'h0000_0080, 32'h0, 4'hF);
        wr(32'h0001_0040, 32'h1234_5678, 4'hF);
        rd("status_oor", 32'h08, 32'h0000_0008);
        rd("in_ptr_oor", 32'h40, 32'h0);

        // Reset arriving together with a request drops its response
        wr(32'h40, 32'hCAFE_0001, 4'hF);
        wr(32'h00, 32'h0, 4'hF);
        check("pre_rst_job", {31'd0, job_valid_o}, 32'd1);
        @(negedge clk_i);
        req_i = 1'b1; wen_i = 1'b1; add_i = 32'h08; id_i = 8'h33; rst_i = 1'b1;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        check("rst_drop_rvalid", {31'd0, r_valid_o}, 32'd0);
        check("rst_drop_job", {31'd0, job_valid_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd("in_ptr_after_rst", 32'h40, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
